// File: rtl/uart_frame_ctrl_if.sv
// Byte-stream and frame-handoff signals between a UART receiver, the frame
// parser and the frame consumer. The parser sits on the slave modport.
interface uart_frame_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_valid;
    logic        frame_ack;
    logic [7:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_payload;
    logic        err_csum;
    logic        err_len;
    logic        err_timeout;
    logic        rx_drop;

    modport master (
        output rx_data, rx_valid, frame_ack,
        input  frame_valid, cmd_addr, cmd_len, cmd_payload,
               err_csum, err_len, err_timeout, rx_drop
    );

    modport slave (
        input  rx_data, rx_valid, frame_ack,
        output frame_valid, cmd_addr, cmd_len, cmd_payload,
               err_csum, err_len, err_timeout, rx_drop
    );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Parses 0x55, ADDR, LEN, PAYLOAD[LEN], CSUM frames and holds them until acked.
// Defining UART_FRAME_TIMEOUT_EN adds an inter-byte timeout that abandons a stalled frame.
module uart_frame_ctrl #(
    parameter int CLK_FREQ      = 50000000,
    parameter int UART_BPS      = 9600,
    parameter int TIMEOUT_BYTES = 3
) (
    input  logic             system_clk,
    input  logic             system_rst,
    uart_frame_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, HOLD} state_t;

    state_t      state_q, state_d;
    logic        frame_valid_q, frame_valid_d;
    logic [7:0]  cmd_addr_q, cmd_addr_d;
    logic [3:0]  cmd_len_q, cmd_len_d;
    logic [63:0] cmd_payload_q, cmd_payload_d;
    logic [7:0]  csum_q, csum_d;
    logic [2:0]  idx_q, idx_d;
    logic        err_csum_q, err_csum_d;
    logic        err_len_q, err_len_d;
    logic        rx_drop_q, rx_drop_d;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TO_LIMIT = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES - 1;
    localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT + 1) : 1;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_timeout_q, err_timeout_d;
    assign bus.err_timeout = err_timeout_q;
`else
    // Timeout parameters have no effect when the timeout feature is left out.
    logic unused_to_cfg;
    assign unused_to_cfg   = ((CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES) != 0;
    assign bus.err_timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        frame_valid_d = frame_valid_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_len_d     = cmd_len_q;
        cmd_payload_d = cmd_payload_q;
        csum_d        = csum_q;
        idx_d         = idx_q;
        err_csum_d    = 1'b0;
        err_len_d     = 1'b0;
        rx_drop_d     = 1'b0;
        case (state_q)
            IDLE: if (bus.rx_valid && bus.rx_data == 8'h55) begin
                state_d       = ADDR;
                cmd_payload_d = '0;
                csum_d        = '0;
                idx_d         = '0;
            end
            ADDR: if (bus.rx_valid) begin
                cmd_addr_d = bus.rx_data;
                csum_d     = csum_q + bus.rx_data;
                state_d    = LEN;
            end
            LEN: if (bus.rx_valid) begin
                if (bus.rx_data != 8'd0 && bus.rx_data <= 8'd8) begin
                    cmd_len_d = bus.rx_data[3:0];
                    csum_d    = csum_q + bus.rx_data;
                    state_d   = DATA;
                end else begin
                    err_len_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DATA: if (bus.rx_valid) begin
                cmd_payload_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
                csum_d = csum_q + bus.rx_data;
                idx_d  = idx_q + 3'd1;
                if ({1'b0, idx_q} == cmd_len_q - 4'd1) state_d = CSUM;
            end
            CSUM: if (bus.rx_valid) begin
                if (bus.rx_data == csum_q) begin
                    frame_valid_d = 1'b1;
                    state_d       = HOLD;
                end else begin
                    err_csum_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            HOLD: begin
                // Bytes arriving while a frame is pending are lost, even on the ack cycle.
                rx_drop_d = bus.rx_valid;
                if (bus.frame_ack) begin
                    frame_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_FRAME_TIMEOUT_EN
        err_timeout_d = 1'b0;
        to_cnt_d      = '0;
        // to_cnt counts idle cycles since the last byte; a byte always wins over expiry.
        if (state_q inside {ADDR, LEN, DATA, CSUM} && !bus.rx_valid) begin
            if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
                err_timeout_d = 1'b1;
                state_d       = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge system_clk or posedge system_rst) begin
        if (system_rst) begin
            state_q       <= IDLE;
            frame_valid_q <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            csum_q        <= '0;
            idx_q         <= '0;
            err_csum_q    <= 1'b0;
            err_len_q     <= 1'b0;
            rx_drop_q     <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            frame_valid_q <= frame_valid_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_len_q     <= cmd_len_d;
            cmd_payload_q <= cmd_payload_d;
            csum_q        <= csum_d;
            idx_q         <= idx_d;
            err_csum_q    <= err_csum_d;
            err_len_q     <= err_len_d;
            rx_drop_q     <= rx_drop_d;
`ifdef UART_FRAME_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    assign bus.frame_valid = frame_valid_q;
    assign bus.cmd_addr    = cmd_addr_q;
    assign bus.cmd_len     = cmd_len_q;
    assign bus.cmd_payload = cmd_payload_q;
    assign bus.err_csum    = err_csum_q;
    assign bus.err_len     = err_len_q;
    assign bus.rx_drop     = rx_drop_q;
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: fixed vector table, directed corner sequences,
// then random frames checked against a queue-based frame model.
module tb_uart_frame_ctrl;
    localparam int CLK_FREQ      = 1000;
    localparam int UART_BPS      = 100;
    localparam int TIMEOUT_BYTES = 1;
    localparam int TO_LIMIT      = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES - 1;
`ifdef UART_FRAME_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_ctrl_if bif();

    uart_frame_ctrl #(
        .CLK_FREQ     (CLK_FREQ),
        .UART_BPS     (UART_BPS),
        .TIMEOUT_BYTES(TIMEOUT_BYTES)
    ) dut (
        .system_clk(clk),
        .system_rst(rst),
        .bus       (bif)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Frame model: bytes of the frame in progress are collected in a queue
    logic [7:0]  mq[$];
    bit          m_hold;
    logic [7:0]  m_addr;
    logic [3:0]  m_len;
    logic [63:0] m_pl;
    bit          p_csum, p_len, p_drop, p_to;
    int          m_idle;

    function automatic void model_clear();
        mq.delete();
        m_hold = 0; m_idle = 0;
        p_csum = 0; p_len = 0; p_drop = 0; p_to = 0;
    endfunction

    function automatic void model_step(bit v, logic [7:0] d, bit ack);
        logic [7:0] sum;
        p_csum = 0; p_len = 0; p_drop = 0; p_to = 0;
        if (m_hold) begin
            if (v) p_drop = 1;
            if (ack) m_hold = 0;
            return;
        end
        if (v) begin
            m_idle = 0;
            if (mq.size() == 0) begin
                if (d == 8'h55) mq.push_back(d);
            end else begin
                mq.push_back(d);
                if (mq.size() == 3 && (d == 8'd0 || d > 8'd8)) begin
                    p_len = 1;
                    mq.delete();
                end else if (mq.size() >= 4 && mq.size() == int'(mq[2]) + 4) begin
                    sum = 8'd0;
                    for (int i = 1; i < mq.size() - 1; i++) sum = sum + mq[i];
                    if (sum == d) begin
                        m_hold = 1;
                        m_addr = mq[1];
                        m_len  = mq[2][3:0];
                        m_pl   = '0;
                        for (int k = 0; k < int'(mq[2]); k++) m_pl[8*k +: 8] = mq[3+k];
                    end else begin
                        p_csum = 1;
                    end
                    mq.delete();
                end
            end
        end else if (TO_EN && mq.size() > 0) begin
            m_idle++;
            if (m_idle == TO_LIMIT) begin
                p_to = 1;
                mq.delete();
                m_idle = 0;
            end
        end
    endfunction

    function automatic void compare_model(string tag);
        chk({tag, " frame_valid"}, bif.frame_valid, m_hold);
        chk({tag, " err_csum"},    bif.err_csum,    p_csum);
        chk({tag, " err_len"},     bif.err_len,     p_len);
        chk({tag, " rx_drop"},     bif.rx_drop,     p_drop);
        chk({tag, " err_timeout"}, bif.err_timeout, p_to);
        if (m_hold) begin
            chk({tag, " cmd_addr"},    bif.cmd_addr,    m_addr);
            chk({tag, " cmd_len"},     bif.cmd_len,     m_len);
            chk({tag, " cmd_payload"}, bif.cmd_payload, m_pl);
        end
    endfunction

    task automatic cycle(input bit v, input logic [7:0] d, input bit ack, input string tag);
        bif.rx_valid  = v;
        bif.rx_data   = d;
        bif.frame_ack = ack;
        @(posedge clk); #1;
        model_step(v, d, ack);
        compare_model(tag);
        bif.rx_valid  = 1'b0;
        bif.frame_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " frame_valid"}, bif.frame_valid, 0);
        chk({tag, " cmd_addr"},    bif.cmd_addr,    0);
        chk({tag, " cmd_len"},     bif.cmd_len,     0);
        chk({tag, " cmd_payload"}, bif.cmd_payload, 0);
        chk({tag, " pulses"}, {bif.err_csum, bif.err_len, bif.err_timeout, bif.rx_drop}, 0);
    endtask

    // Reset is raised mid-cycle and its effect is checked before the next clock edge.
    task automatic pulse_reset(input string tag);
        bif.rx_valid  = 1'b0;
        bif.frame_ack = 1'b0;
        rst = 1'b1;
        #2;
        check_all_zero(tag);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         ack;
        bit         fv, ecs, eln, drp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit v, logic [7:0] d, bit ack, bit fv, bit ecs, bit eln, bit drp);
        vec_t r;
        r = '{v, d, ack, fv, ecs, eln, drp};
        tbl.push_back(r);
    endfunction

    task automatic send(input logic [7:0] d);
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) cycle(1'b0, 8'h00, $urandom_range(0, 3) == 0, "rnd");
        cycle(1'b1, d, $urandom_range(0, 5) == 0, "rnd");
    endtask

    initial begin
        logic [7:0] addr, sum, len;
        int kind;
        bif.rx_valid = 1'b0; bif.rx_data = 8'h00; bif.frame_ack = 1'b0;
        rst = 1'b0;
        model_clear();

        // good frame, five drops while holding, then ack
        add(1, 8'h55, 0, 0, 0, 0, 0); add(1, 8'h10, 0, 0, 0, 0, 0); add(1, 8'h02, 0, 0, 0, 0, 0);
        add(1, 8'hAA, 0, 0, 0, 0, 0); add(1, 8'hBB, 0, 0, 0, 0, 0); add(1, 8'h77, 0, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0);
        add(1, 8'h55, 0, 1, 0, 0, 1); add(1, 8'h01, 0, 1, 0, 0, 1); add(1, 8'h01, 0, 1, 0, 0, 1);
        add(1, 8'h05, 0, 1, 0, 0, 1); add(1, 8'h07, 0, 1, 0, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0);
        // bad checksum, then the good frame again
        add(1, 8'h55, 0, 0, 0, 0, 0); add(1, 8'h10, 0, 0, 0, 0, 0); add(1, 8'h02, 0, 0, 0, 0, 0);
        add(1, 8'hAA, 0, 0, 0, 0, 0); add(1, 8'hBB, 0, 0, 0, 0, 0); add(1, 8'h78, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 8'h55, 0, 0, 0, 0, 0); add(1, 8'h10, 0, 0, 0, 0, 0); add(1, 8'h02, 0, 0, 0, 0, 0);
        add(1, 8'hAA, 0, 0, 0, 0, 0); add(1, 8'hBB, 0, 0, 0, 0, 0); add(1, 8'h77, 0, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0);
        // bad length, then garbage and a stray ack
        add(1, 8'h55, 0, 0, 0, 0, 0); add(1, 8'h10, 0, 0, 0, 0, 0); add(1, 8'h09, 0, 0, 0, 1, 0);
        add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'hFF, 0, 0, 0, 0, 0); add(1, 8'h12, 1, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0);

        #1 rst = 1'b1;
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            bif.rx_valid  = tbl[i].v;
            bif.rx_data   = tbl[i].d;
            bif.frame_ack = tbl[i].ack;
            @(posedge clk); #1;
            model_step(tbl[i].v, tbl[i].d, tbl[i].ack);
            chk($sformatf("vec%0d frame_valid", i), bif.frame_valid, tbl[i].fv);
            chk($sformatf("vec%0d err_csum", i),    bif.err_csum,    tbl[i].ecs);
            chk($sformatf("vec%0d err_len", i),     bif.err_len,     tbl[i].eln);
            chk($sformatf("vec%0d rx_drop", i),     bif.rx_drop,     tbl[i].drp);
            chk($sformatf("vec%0d err_timeout", i), bif.err_timeout, 0);
            if (tbl[i].fv) begin
                chk($sformatf("vec%0d cmd_addr", i),    bif.cmd_addr,    8'h10);
                chk($sformatf("vec%0d cmd_len", i),     bif.cmd_len,     4'd2);
                chk($sformatf("vec%0d cmd_payload", i), bif.cmd_payload, 64'h0000_0000_0000_BBAA);
            end
            bif.rx_valid = 1'b0; bif.frame_ack = 1'b0;
        end

        // byte on the ack cycle is dropped; the same bytes sent afterwards form a frame
        cycle(1, 8'h55, 0, "ackdrop"); cycle(1, 8'h33, 0, "ackdrop"); cycle(1, 8'h01, 0, "ackdrop");
        cycle(1, 8'h44, 0, "ackdrop"); cycle(1, 8'h78, 0, "ackdrop");
        cycle(1, 8'h55, 1, "ackdrop");
        cycle(1, 8'h55, 0, "refr"); cycle(1, 8'h01, 0, "refr"); cycle(1, 8'h01, 0, "refr");
        cycle(1, 8'h05, 0, "refr"); cycle(1, 8'h07, 0, "refr");
        chk("refr payload", bif.cmd_payload, 64'h05);
        cycle(0, 8'h00, 1, "refr");

        // inter-byte gaps: byte at cycle 98, byte on the expiry cycle, then a full idle timeout
        cycle(1, 8'h55, 0, "gap");
        for (int k = 0; k < 97; k++) cycle(0, 8'h00, 0, "gap");
        cycle(1, 8'h10, 0, "gap98");
        for (int k = 0; k < 98; k++) cycle(0, 8'h00, 0, "gap");
        cycle(1, 8'h02, 0, "gap99");
        for (int k = 0; k < 99; k++) cycle(0, 8'h00, 0, "gapto");
        cycle(0, 8'h00, 0, "gapto");
        pulse_reset("rst_gap");

        // reset in the middle of a frame, then a clean frame
        cycle(1, 8'h55, 0, "midrst"); cycle(1, 8'h10, 0, "midrst");
        cycle(1, 8'h03, 0, "midrst"); cycle(1, 8'hAA, 0, "midrst");
        pulse_reset("rst_mid");
        cycle(1, 8'h55, 0, "post"); cycle(1, 8'h20, 0, "post"); cycle(1, 8'h01, 0, "post");
        cycle(1, 8'h01, 0, "post"); cycle(1, 8'h22, 0, "post");
        chk("post frame_valid", bif.frame_valid, 1'b1);
        chk("post cmd_addr", bif.cmd_addr, 8'h20);
        pulse_reset("rst_hold");

        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 5);
            addr = 8'($urandom);
            len  = 8'($urandom_range(1, 8));
            if (kind == 4) begin
                send(8'($urandom));
            end else if (kind == 3) begin
                send(8'h55); send(addr);
                send(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255)));
            end else begin
                send(8'h55); send(addr); send(len);
                sum = addr + len;
                for (int k = 0; k < int'(len); k++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    sum = sum + b;
                    send(b);
                end
                send((kind == 2) ? sum ^ 8'($urandom_range(1, 255)) : sum);
            end
        end
        cycle(0, 8'h00, 1, "tail");
        cycle(0, 8'h00, 0, "tail");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
